// File: rtl/mips_rf_pkg.sv
// Shared constants and helpers for the MIPS32 register file family.
package mips_rf_pkg;

   localparam int DEF_BUS_SIZE = 32;
   localparam int DEF_DIR_SIZE = 5;

   // Smallest r with 2**r >= value (elaboration-time helper).
   function automatic int rf_log2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((32'sd1 <<< i) < value) begin
            r = i + 1;
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/rf_bypass_mux.sv
// One read port: selects array data or same-cycle write data (highest port wins),
// and masks the busy bit when a writeback is being bypassed.
module rf_bypass_mux
   import mips_rf_pkg::*;
#(
   parameter int BUS_SIZE          = DEF_BUS_SIZE,
   parameter int DIR_SIZE_INTERNAL = DEF_DIR_SIZE,
   parameter int NW                = 1,
   parameter int ZERO_REG          = 1,
   parameter int WRITE_FIRST       = 1
) (
   input  logic                            rst,
   input  logic [DIR_SIZE_INTERNAL-1:0]    rdAddr,
   input  logic [BUS_SIZE-1:0]             arrData,
   input  logic                            arrBusy,
   input  logic [NW-1:0]                   wrEn,
   input  logic [NW*DIR_SIZE_INTERNAL-1:0] wrAddr,
   input  logic [NW*BUS_SIZE-1:0]          wrData,
   output logic [BUS_SIZE-1:0]             rdData,
   output logic                            rdBusy
);

   logic [NW-1:0]       match_s;
   logic [BUS_SIZE-1:0] byp_data_s;
   logic                use_byp_s;
   logic                is_zero_s;

   // Port match, priority select and r0/reset masking.
   always_comb begin
      byp_data_s = arrData;
      for (int k = 0; k < NW; k++) begin
         match_s[k] = wrEn[k] & (wrAddr[k*DIR_SIZE_INTERNAL +: DIR_SIZE_INTERNAL] == rdAddr);
         byp_data_s = match_s[k] ? wrData[k*BUS_SIZE +: BUS_SIZE] : byp_data_s;
      end
      is_zero_s = (ZERO_REG != 0) && (rdAddr == '0);
      use_byp_s = (WRITE_FIRST != 0) && (|match_s) && !rst;
      if (is_zero_s) begin
         rdData = '0;
         rdBusy = 1'b0;
      end else if (rst) begin
         rdData = arrData;
         rdBusy = 1'b0;
      end else begin
         rdData = use_byp_s ? byp_data_s : arrData;
         rdBusy = arrBusy & ~use_byp_s;
      end
   end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file with per-register in-flight (busy) scoreboard.
module regfile_mp_sb
   import mips_rf_pkg::*;
#(
   parameter int BUS_SIZE          = DEF_BUS_SIZE,
   parameter int DIR_SIZE_INTERNAL = DEF_DIR_SIZE,
   parameter int NR                = 2,
   parameter int NW                = 1,
   parameter int ZERO_REG          = 1,
   parameter int WRITE_FIRST       = 1
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NW-1:0]                   wrEn,
   input  logic [NW*DIR_SIZE_INTERNAL-1:0] wrAddr,
   input  logic [NW*BUS_SIZE-1:0]          wrData,
   input  logic                            rsvEn,
   input  logic [DIR_SIZE_INTERNAL-1:0]    rsvAddr,
   input  logic [NR*DIR_SIZE_INTERNAL-1:0] rdAddr,
   output logic [NR*BUS_SIZE-1:0]          rdData,
   output logic [NR-1:0]                   rdBusy,
   output logic                            anyBusy
);

   localparam int A     = DIR_SIZE_INTERNAL;
   localparam int W     = BUS_SIZE;
   localparam int DEPTH = 1 << DIR_SIZE_INTERNAL;

   logic [W-1:0]     regs_q [DEPTH];
   logic [W-1:0]     regs_d [DEPTH];
   logic [DEPTH-1:0] busy_q;
   logic [DEPTH-1:0] busy_d;
   logic             any_busy_q;
   logic [NW-1:0]    wr_ok_s;
   logic             clr_s;
   logic             set_s;

   // Next-state for array and scoreboard; higher write port overrides lower on data.
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      for (int k = 0; k < NW; k++) begin
         wr_ok_s[k] = wrEn[k] & ~((ZERO_REG != 0) && (wrAddr[k*A +: A] == '0));
      end
      for (int a = 0; a < DEPTH; a++) begin
         clr_s = 1'b0;
         for (int k = 0; k < NW; k++) begin
            regs_d[a] = (wr_ok_s[k] && (wrAddr[k*A +: A] == A'(a))) ? wrData[k*W +: W] : regs_d[a];
            clr_s     = clr_s | (wrEn[k] & (wrAddr[k*A +: A] == A'(a)));
         end
         set_s     = rsvEn & (rsvAddr == A'(a)) & ~((ZERO_REG != 0) && (a == 0));
         busy_d[a] = (busy_q[a] & ~clr_s) | set_s;
      end
   end

   // Storage, busy vector and drain flag with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int a = 0; a < DEPTH; a++) begin
            regs_q[a] <= '0;
         end
         busy_q     <= '0;
         any_busy_q <= 1'b0;
      end else begin
         regs_q     <= regs_d;
         busy_q     <= busy_d;
         any_busy_q <= |busy_d;
      end
   end

   assign anyBusy = any_busy_q;

   for (genvar i = 0; i < NR; i++) begin : g_rd
      logic [A-1:0] addr_s;
      assign addr_s = rdAddr[i*A +: A];

      rf_bypass_mux #(
         .BUS_SIZE          (BUS_SIZE),
         .DIR_SIZE_INTERNAL (DIR_SIZE_INTERNAL),
         .NW                (NW),
         .ZERO_REG          (ZERO_REG),
         .WRITE_FIRST       (WRITE_FIRST)
      ) u_mux (
         .rst     (rst),
         .rdAddr  (addr_s),
         .arrData (regs_q[addr_s]),
         .arrBusy (busy_q[addr_s]),
         .wrEn    (wrEn),
         .wrAddr  (wrAddr),
         .wrData  (wrData),
         .rdData  (rdData[i*W +: W]),
         .rdBusy  (rdBusy[i])
      );
   end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench: a 2-write-port write-first instance and a 1-write-port read-old instance.
module tb_regfile_mp_sb;

   logic        clk;
   logic        rst;
   logic [1:0]  wr_en;
   logic [9:0]  wr_addr;
   logic [63:0] wr_data;
   logic        rsv_en;
   logic [4:0]  rsv_addr;
   logic [9:0]  rd_addr;
   logic [63:0] rd_data;
   logic [1:0]  rd_busy;
   logic        any_busy;

   logic [0:0]  wr_en0;
   logic [4:0]  wr_addr0;
   logic [31:0] wr_data0;
   logic        rsv_en0;
   logic [4:0]  rsv_addr0;
   logic [9:0]  rd_addr0;
   logic [63:0] rd_data0;
   logic [1:0]  rd_busy0;
   logic        any_busy0;

   int vectors;
   int miscompares;

   regfile_mp_sb #(.NR(2), .NW(2), .ZERO_REG(1), .WRITE_FIRST(1)) dut (
      .clk(clk), .rst(rst), .wrEn(wr_en), .wrAddr(wr_addr), .wrData(wr_data),
      .rsvEn(rsv_en), .rsvAddr(rsv_addr), .rdAddr(rd_addr),
      .rdData(rd_data), .rdBusy(rd_busy), .anyBusy(any_busy)
   );

   regfile_mp_sb #(.NR(2), .NW(1), .ZERO_REG(1), .WRITE_FIRST(0)) dut_ro (
      .clk(clk), .rst(rst), .wrEn(wr_en0), .wrAddr(wr_addr0), .wrData(wr_data0),
      .rsvEn(rsv_en0), .rsvAddr(rsv_addr0), .rdAddr(rd_addr0),
      .rdData(rd_data0), .rdBusy(rd_busy0), .anyBusy(any_busy0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      wr_en = 2'b00; wr_addr = 10'd0; wr_data = 64'd0; rsv_en = 1'b0; rsv_addr = 5'd0;
      wr_en0 = 1'b0; wr_addr0 = 5'd0; wr_data0 = 32'd0; rsv_en0 = 1'b0; rsv_addr0 = 5'd0;
   endtask

   task automatic test_reset();
      rst = 1'b1; idle(); rd_addr = 10'd0; rd_addr0 = 10'd0;
      tick();
      rst = 1'b0;
      wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'd0, 32'd20};
      rsv_en = 1'b1; rsv_addr = 5'd9;
      tick();
      idle(); rd_addr = {5'd9, 5'd5}; #1;
      vectors++; if (rd_data[31:0] !== 32'd20) begin miscompares++; $display("FAIL preload r5: got %0d want 20", rd_data[31:0]); end
      vectors++; if (rd_busy[1] !== 1'b1) begin miscompares++; $display("FAIL preload busy r9: got %b want 1", rd_busy[1]); end
      rst = 1'b1; wr_en = 2'b01; wr_addr = {5'd0, 5'd6}; wr_data = {32'd0, 32'd55};
      rsv_en = 1'b1; rsv_addr = 5'd3; #1;
      vectors++; if (rd_busy !== 2'b00) begin miscompares++; $display("FAIL busy during rst: got %b want 00", rd_busy); end
      tick();
      rst = 1'b0; idle(); rd_addr = {5'd6, 5'd5}; #1;
      vectors++; if (rd_data !== 64'd0) begin miscompares++; $display("FAIL reset data r5/r6: got %h want 0", rd_data); end
      vectors++; if (any_busy !== 1'b0) begin miscompares++; $display("FAIL reset anyBusy: got %b want 0", any_busy); end
      rd_addr = {5'd3, 5'd9}; #1;
      vectors++; if (rd_busy !== 2'b00) begin miscompares++; $display("FAIL reset busy r3/r9: got %b want 00", rd_busy); end
   endtask

   task automatic test_bypass();
      wr_en = 2'b01; wr_addr = {5'd0, 5'd5}; wr_data = {32'd0, 32'd20}; rd_addr = {5'd0, 5'd5};
      wr_en0 = 1'b1; wr_addr0 = 5'd5; wr_data0 = 32'd20; rd_addr0 = {5'd0, 5'd5}; #1;
      vectors++; if (rd_data[31:0] !== 32'd20) begin miscompares++; $display("FAIL write-first bypass: got %0d want 20", rd_data[31:0]); end
      vectors++; if (rd_data0[31:0] !== 32'd0) begin miscompares++; $display("FAIL read-old same cycle: got %0d want 0", rd_data0[31:0]); end
      tick();
      idle(); #1;
      vectors++; if (rd_data0[31:0] !== 32'd20) begin miscompares++; $display("FAIL read-old after edge: got %0d want 20", rd_data0[31:0]); end
      rsv_en0 = 1'b1; rsv_addr0 = 5'd8;
      tick();
      idle(); wr_en0 = 1'b1; wr_addr0 = 5'd8; wr_data0 = 32'd44; rd_addr0 = {5'd0, 5'd8}; #1;
      vectors++; if (rd_busy0[0] !== 1'b1) begin miscompares++; $display("FAIL read-old busy no bypass: got %b want 1", rd_busy0[0]); end
      tick();
      idle(); #1;
      vectors++; if ({rd_busy0[0], any_busy0, rd_data0[31:0]} !== {1'b0, 1'b0, 32'd44}) begin
         miscompares++; $display("FAIL read-old writeback: got %b %b %0d want 0 0 44", rd_busy0[0], any_busy0, rd_data0[31:0]); end
   endtask

   task automatic test_zero_reg();
      wr_en = 2'b01; wr_addr = 10'd0; wr_data = {32'd0, 32'hDEADBEEF};
      rsv_en = 1'b1; rsv_addr = 5'd0; rd_addr = 10'd0; #1;
      vectors++; if ({rd_data[31:0], rd_busy[0]} !== {32'd0, 1'b0}) begin
         miscompares++; $display("FAIL r0 same cycle: got %h %b want 0 0", rd_data[31:0], rd_busy[0]); end
      tick();
      idle(); #1;
      vectors++; if ({rd_data[31:0], rd_busy[0], any_busy} !== {32'd0, 1'b0, 1'b0}) begin
         miscompares++; $display("FAIL r0 after edge: got %h %b %b want 0 0 0", rd_data[31:0], rd_busy[0], any_busy); end
   endtask

   task automatic test_scoreboard();
      rsv_en = 1'b1; rsv_addr = 5'd12; rd_addr = {5'd12, 5'd0};
      tick();
      idle(); #1;
      vectors++; if ({rd_busy[1], any_busy} !== 2'b11) begin miscompares++; $display("FAIL reserve r12: got %b%b want 11", rd_busy[1], any_busy); end
      wr_en = 2'b01; wr_addr = {5'd0, 5'd12}; wr_data = {32'd0, 32'd3}; #1;
      vectors++; if ({rd_busy[1], rd_data[63:32]} !== {1'b0, 32'd3}) begin
         miscompares++; $display("FAIL writeback bypass r12: got %b %0d want 0 3", rd_busy[1], rd_data[63:32]); end
      tick();
      idle(); #1;
      vectors++; if ({rd_busy[1], any_busy, rd_data[63:32]} !== {1'b0, 1'b0, 32'd3}) begin
         miscompares++; $display("FAIL writeback r12: got %b %b %0d want 0 0 3", rd_busy[1], any_busy, rd_data[63:32]); end
      rsv_en = 1'b1; rsv_addr = 5'd31; rd_addr = {5'd31, 5'd0}; #1;
      vectors++; if (rd_busy[1] !== 1'b0) begin miscompares++; $display("FAIL pre-edge busy r31: got %b want 0", rd_busy[1]); end
      tick();
      idle(); #1;
      vectors++; if (rd_busy[1] !== 1'b1) begin miscompares++; $display("FAIL reserve r31: got %b want 1", rd_busy[1]); end
      wr_en = 2'b10; wr_addr = {5'd31, 5'd0}; wr_data = {32'h00001234, 32'd0};
      tick();
      idle(); #1;
      vectors++; if ({rd_busy[1], rd_data[63:32]} !== {1'b0, 32'h00001234}) begin
         miscompares++; $display("FAIL writeback r31: got %b %h want 0 00001234", rd_busy[1], rd_data[63:32]); end
   endtask

   task automatic test_set_vs_clear();
      rsv_en = 1'b1; rsv_addr = 5'd7; wr_en = 2'b01; wr_addr = {5'd0, 5'd7}; wr_data = {32'd0, 32'd9};
      rd_addr = {5'd0, 5'd7};
      tick();
      idle(); #1;
      vectors++; if ({rd_data[31:0], rd_busy[0], any_busy} !== {32'd9, 1'b1, 1'b1}) begin
         miscompares++; $display("FAIL set-vs-clear r7: got %0d %b %b want 9 1 1", rd_data[31:0], rd_busy[0], any_busy); end
      wr_en = 2'b01; wr_addr = {5'd0, 5'd7}; wr_data = {32'd0, 32'd10};
      tick();
      idle(); #1;
      vectors++; if ({rd_data[31:0], rd_busy[0], any_busy} !== {32'd10, 1'b0, 1'b0}) begin
         miscompares++; $display("FAIL r7 final writeback: got %0d %b %b want 10 0 0", rd_data[31:0], rd_busy[0], any_busy); end
   endtask

   task automatic test_port_conflict();
      rsv_en = 1'b1; rsv_addr = 5'd12;
      tick();
      idle(); wr_en = 2'b11; wr_addr = {5'd12, 5'd12}; wr_data = {32'd2, 32'd1};
      rd_addr = {5'd0, 5'd12}; #1;
      vectors++; if ({rd_data[31:0], rd_busy[0]} !== {32'd2, 1'b0}) begin
         miscompares++; $display("FAIL conflict bypass: got %0d %b want 2 0", rd_data[31:0], rd_busy[0]); end
      tick();
      idle(); #1;
      vectors++; if ({rd_data[31:0], rd_busy[0], any_busy} !== {32'd2, 1'b0, 1'b0}) begin
         miscompares++; $display("FAIL conflict r12: got %0d %b %b want 2 0 0", rd_data[31:0], rd_busy[0], any_busy); end
      rsv_en = 1'b1; rsv_addr = 5'd20; rd_addr = {5'd20, 5'd12};
      tick();
      idle(); #1;
      vectors++; if (any_busy !== 1'b1) begin miscompares++; $display("FAIL reserve r20: got %b want 1", any_busy); end
      rst = 1'b1;
      tick();
      rst = 1'b0; wr_en = 2'b01; wr_addr = {5'd0, 5'd20}; wr_data = {32'd0, 32'd77}; #1;
      vectors++; if ({rd_busy, any_busy} !== 3'b000) begin
         miscompares++; $display("FAIL rst discards rsv: got %b %b want 00 0", rd_busy, any_busy); end
      tick();
      idle(); #1;
      vectors++; if ({rd_data[63:32], rd_data[31:0]} !== {32'd77, 32'd0}) begin
         miscompares++; $display("FAIL post-rst writeback: got %0d %0d want 77 0", rd_data[63:32], rd_data[31:0]); end
   endtask

   initial begin
      vectors = 0;
      miscompares = 0;
      test_reset();
      test_bypass();
      test_zero_reg();
      test_scoreboard();
      test_set_vs_clear();
      test_port_conflict();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
